// File: rtl/bist_pkg.sv
// Shared types and march element tables for the SRAM BIST engine.
package bist_pkg;

  localparam logic [2:0] MODE_MARCH_C = 3'b001;
  localparam logic [2:0] MODE_MATS    = 3'b010;

  localparam logic [7:0] DATA0 = 8'h00;
  localparam logic [7:0] DATA1 = 8'hFF;

  typedef enum logic [2:0] {
    OP_W0,
    OP_W1,
    OP_R0,
    OP_R1,
    OP_NOP
  } op_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_RCV,
    S_DONE
  } state_e;

  typedef struct packed {
    dir_e dir;
    op_e  op0;
    op_e  op1;
  } elem_t;

  // Unused slots are padded with NOP so any 3-bit index is safe.
  localparam elem_t MARCH_C_TBL [8] = '{
    '{DIR_UP,   OP_W0,  OP_NOP},
    '{DIR_UP,   OP_R0,  OP_W1},
    '{DIR_UP,   OP_R1,  OP_W0},
    '{DIR_DOWN, OP_R0,  OP_W1},
    '{DIR_DOWN, OP_R1,  OP_W0},
    '{DIR_UP,   OP_R0,  OP_NOP},
    '{DIR_UP,   OP_NOP, OP_NOP},
    '{DIR_UP,   OP_NOP, OP_NOP}
  };

  localparam elem_t MATS_TBL [8] = '{
    '{DIR_UP,   OP_W0,  OP_NOP},
    '{DIR_UP,   OP_R0,  OP_W1},
    '{DIR_DOWN, OP_R1,  OP_W0},
    '{DIR_UP,   OP_NOP, OP_NOP},
    '{DIR_UP,   OP_NOP, OP_NOP},
    '{DIR_UP,   OP_NOP, OP_NOP},
    '{DIR_UP,   OP_NOP, OP_NOP},
    '{DIR_UP,   OP_NOP, OP_NOP}
  };

  function automatic logic mode_legal(
    input logic [2:0] m
  );
    return (m == MODE_MARCH_C) || (m == MODE_MATS);
  endfunction

  function automatic logic [2:0] num_elems(
    input logic [2:0] m
  );
    logic [2:0] n;
    n = 3'd0;
    case (m)
      MODE_MARCH_C: n = 3'd6;
      MODE_MATS:    n = 3'd3;
      default:      n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic elem_t elem_at(
    input logic [2:0] m,
    input logic [2:0] i
  );
    elem_t e;
    e = '{DIR_UP, OP_NOP, OP_NOP};
    case (m)
      MODE_MARCH_C: e = MARCH_C_TBL[i];
      MODE_MATS:    e = MATS_TBL[i];
      default:      e = '{DIR_UP, OP_NOP, OP_NOP};
    endcase
    return e;
  endfunction

  function automatic op_e elem_op(
    input logic [2:0] m,
    input logic [2:0] i,
    input logic       k
  );
    elem_t e;
    e = elem_at(m, i);
    return k ? e.op1 : e.op0;
  endfunction

  function automatic logic elem_down(
    input logic [2:0] m,
    input logic [2:0] i
  );
    elem_t e;
    e = elem_at(m, i);
    return e.dir == DIR_DOWN;
  endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Loadable up/down address counter over 0..ADDR_MAX with a
// terminal-address flag for the current sweep direction.
module bist_addr_gen #(
  parameter int          AW       = 16,
  parameter int unsigned ADDR_MAX = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          down,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [AW-1:0] TOP = AW'(ADDR_MAX);

  logic down_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr   <= '0;
      down_q <= 1'b0;
    end else if (load) begin
      addr   <= down ? TOP : '0;
      down_q <= down;
    end else if (step) begin
      addr <= down_q ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = down_q ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/bist_march_engine.sv
// March-test sequencer driving an SRAM port: FSM, element/op
// indexing, read-data comparison and fail bookkeeping.
module bist_march_engine
  import bist_pkg::*;
#(
  parameter int          AW       = 16,
  parameter int          DW       = 8,
  parameter int unsigned ADDR_MAX = 65535
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          BIST_EN,
  input  logic [2:0]    BIST_MODE,
  input  logic [DW-1:0] ODATA,
  output logic [AW-1:0] ADDR,
  output logic          CE,
  output logic          CSB,
  output logic          WEB,
  output logic          OEB,
  output logic [DW-1:0] IDATA,
  output logic          BIST_BUSY,
  output logic          BIST_DONE,
  output logic          BIST_PASS,
  output logic [AW-1:0] FAIL_ADDR,
  output logic [7:0]    FAIL_CNT
);

  state_e        state;
  state_e        state_n;
  logic [2:0]    mode_q;
  logic          legal_q;
  logic [2:0]    elem_idx;
  logic          op_idx;
  logic [7:0]    fail_cnt;
  logic [AW-1:0] fail_addr;

  logic          ag_load;
  logic          ag_down;
  logic          ag_step;
  logic          ag_last;
  logic [AW-1:0] addr;

  logic          start;
  logic          adv_op;
  logic          adv_elem;

  op_e           op;
  logic          has_op1;
  logic          last_elem;
  logic          is_wr;
  logic          is_rd;
  logic [DW-1:0] bg_data;
  logic          miscmp;

  bist_addr_gen #(
    .AW       (AW),
    .ADDR_MAX (ADDR_MAX)
  ) u_addr_gen (
    .clk  (CLK),
    .rst  (RST),
    .load (ag_load),
    .down (ag_down),
    .step (ag_step),
    .addr (addr),
    .last (ag_last)
  );

  assign op        = elem_op(mode_q, elem_idx, op_idx);
  assign has_op1   = elem_op(mode_q, elem_idx, 1'b1) != OP_NOP;
  assign last_elem = (elem_idx + 3'd1) == num_elems(mode_q);
  assign is_wr     = (op == OP_W0) || (op == OP_W1);
  assign is_rd     = (op == OP_R0) || (op == OP_R1);
  assign bg_data   = ((op == OP_W1) || (op == OP_R1)) ?
                     DW'(DATA1) : DW'(DATA0);
  assign miscmp    = (state == S_RCV) && is_rd && (ODATA != bg_data);

  always_comb begin
    state_n  = state;
    ag_load  = 1'b0;
    ag_down  = 1'b0;
    ag_step  = 1'b0;
    start    = 1'b0;
    adv_op   = 1'b0;
    adv_elem = 1'b0;
    unique case (state)
      S_IDLE: begin
        ag_load = 1'b1;
        if (BIST_EN) begin
          start   = 1'b1;
          state_n = mode_legal(BIST_MODE) ? S_ACC : S_DONE;
        end
      end
      S_ACC: begin
        state_n = BIST_EN ? S_RCV : S_IDLE;
      end
      S_RCV: begin
        if (!BIST_EN) begin
          state_n = S_IDLE;
        end else if (!op_idx && has_op1) begin
          adv_op  = 1'b1;
          state_n = S_ACC;
        end else if (!ag_last) begin
          ag_step = 1'b1;
          state_n = S_ACC;
        end else if (last_elem) begin
          state_n = S_DONE;
        end else begin
          // Each element restarts at its own sweep origin.
          ag_load  = 1'b1;
          ag_down  = elem_down(mode_q, elem_idx + 3'd1);
          adv_elem = 1'b1;
          state_n  = S_ACC;
        end
      end
      S_DONE: begin
        if (!BIST_EN) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      mode_q    <= 3'd0;
      legal_q   <= 1'b0;
      elem_idx  <= 3'd0;
      op_idx    <= 1'b0;
      fail_cnt  <= 8'd0;
      fail_addr <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        mode_q    <= BIST_MODE;
        legal_q   <= mode_legal(BIST_MODE);
        elem_idx  <= 3'd0;
        op_idx    <= 1'b0;
        fail_cnt  <= 8'd0;
        fail_addr <= '0;
      end else begin
        if (adv_op) begin
          op_idx <= 1'b1;
        end else if (ag_step) begin
          op_idx <= 1'b0;
        end else if (adv_elem) begin
          elem_idx <= elem_idx + 3'd1;
          op_idx   <= 1'b0;
        end
        if (miscmp) begin
          if (fail_cnt == 8'd0) fail_addr <= addr;
          if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
        end
      end
    end
  end

  assign ADDR      = addr;
  assign CE        = (state == S_ACC);
  assign CSB       = ~CE;
  assign WEB       = ~(CE & is_wr);
  assign OEB       = ~(((state == S_ACC) || (state == S_RCV)) & is_rd);
  assign IDATA     = (CE & is_wr) ? bg_data : '0;
  assign BIST_BUSY = (state == S_ACC) || (state == S_RCV);
  assign BIST_DONE = (state == S_DONE);
  assign BIST_PASS = (state == S_DONE) && legal_q && (fail_cnt == 8'd0);
  assign FAIL_ADDR = fail_addr;
  assign FAIL_CNT  = fail_cnt;

endmodule

// File: tb/tb_bist_march_engine.sv
// Scoreboard bench: string-described march model predicts every
// SRAM access and the final verdict; a monitor checks each CE pulse.
module tb_bist_march_engine;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [DW-1:0] odata = '0;
  logic [AW-1:0] ADDR;
  logic          CE, CSB, WEB, OEB;
  logic [DW-1:0] IDATA;
  logic          BUSY, DONE, PASS;
  logic [AW-1:0] FAIL_ADDR;
  logic [7:0]    FAIL_CNT;

  bist_march_engine #(.AW(AW), .DW(DW), .ADDR_MAX(N - 1)) dut (
    .CLK       (clk),
    .RST       (rst),
    .BIST_EN   (en),
    .BIST_MODE (mode),
    .ODATA     (odata),
    .ADDR      (ADDR),
    .CE        (CE),
    .CSB       (CSB),
    .WEB       (WEB),
    .OEB       (OEB),
    .IDATA     (IDATA),
    .BIST_BUSY (BUSY),
    .BIST_DONE (DONE),
    .BIST_PASS (PASS),
    .FAIL_ADDR (FAIL_ADDR),
    .FAIL_CNT  (FAIL_CNT)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // SRAM model with an optional stuck-at fault on one word
  logic [7:0] mem [N];
  int         flt_addr = -1;
  logic [7:0] flt_mask = 8'h00;
  logic       flt_one  = 1'b0;

  function automatic logic [7:0] faulty(input logic [7:0] v, input int a);
    if (a != flt_addr) return v;
    return flt_one ? (v | flt_mask) : (v & ~flt_mask);
  endfunction

  always @(posedge clk) begin
    if (CE && !CSB) begin
      if (!WEB) mem[ADDR[3:0]] <= IDATA;
      else if (!OEB) odata <= faulty(mem[ADDR[3:0]], int'(ADDR[3:0]));
    end
  end

  typedef struct {
    logic       wr;
    logic [15:0] a;
    logic [7:0]  d;
  } acc_t;

  acc_t exp_q[$];
  int   exp_cnt, exp_faddr, exp_ops, exp_cycles, ce_cnt;
  logic exp_pass;

  // Elements as text: '^'/'v' direction then op pairs like "r0w1".
  task automatic model(input logic [2:0] m);
    string      els[$];
    logic [7:0] mm [N];
    int         a;
    logic [7:0] d, rd;
    exp_q.delete();
    exp_cnt = 0; exp_faddr = 0; exp_ops = 0; ce_cnt = 0;
    if (m == 3'b001) els = '{"^w0", "^r0w1", "^r1w0", "vr0w1", "vr1w0", "^r0"};
    else if (m == 3'b010) els = '{"^w0", "^r0w1", "vr1w0"};
    else els = '{};
    foreach (els[e]) begin
      for (int k = 0; k < N; k++) begin
        a = (els[e][0] == "v") ? N - 1 - k : k;
        for (int p = 1; p < els[e].len(); p += 2) begin
          d = (els[e][p+1] == "1") ? 8'hFF : 8'h00;
          exp_ops++;
          if (els[e][p] == "w") begin
            mm[a] = d;
            exp_q.push_back('{1'b1, 16'(a), d});
          end else begin
            exp_q.push_back('{1'b0, 16'(a), d});
            rd = faulty(mm[a], a);
            if (rd != d) begin
              if (exp_cnt == 0) exp_faddr = a;
              if (exp_cnt < 255) exp_cnt++;
            end
          end
        end
      end
    end
    exp_pass   = (els.size() > 0) && (exp_cnt == 0);
    exp_cycles = 2 * exp_ops + 1;
  endtask

  always @(negedge clk) begin
    acc_t e;
    if (CE === 1'b1) begin
      ce_cnt++;
      if (exp_q.size() == 0) begin
        check("extra_access", {ADDR, WEB}, 17'h1FFFF);
      end else begin
        e = exp_q.pop_front();
        check("access", {ADDR, WEB, OEB, CSB, IDATA},
              {e.a, ~e.wr, e.wr, 1'b0, e.wr ? e.d : 8'h00});
      end
    end
  end

  task automatic wait_done();
    int cyc = 0;
    while (DONE !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 7) mode = 3'($urandom);
    end
    check("done_latency", cyc, exp_cycles);
    check("pass", PASS, exp_pass);
    check("busy_at_done", BUSY, 1'b0);
    check("fail_cnt", FAIL_CNT, exp_cnt);
    check("fail_addr", FAIL_ADDR, exp_faddr);
    check("ce_pulses", ce_cnt, exp_ops);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run(input logic [2:0] m);
    model(m);
    mode = m;
    en   = 1'b1;
    wait_done();
    en = 1'b0;
    @(posedge clk); #1;
    check("clear_on_en_low", {DONE, PASS, BUSY}, 3'b000);
    check("fail_cnt_hold", FAIL_CNT, exp_cnt);
  endtask

  logic [2:0] rm;

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_state",
          {ADDR, CE, CSB, WEB, OEB, IDATA, BUSY, DONE, PASS, FAIL_ADDR, FAIL_CNT},
          {16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 3'b000, 16'h0, 8'h00});
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    run(3'b001);
    run(3'b010);

    flt_addr = 5; flt_mask = 8'h01; flt_one = 1'b0;
    run(3'b001);
    flt_addr = -1;

    run(3'b011);

    // Abort mid-run, then a clean rerun
    model(3'b001);
    mode = 3'b001; en = 1'b1;
    repeat (50) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {BUSY, DONE, PASS, CSB, CE}, 5'b00010);
    exp_q.delete();
    run(3'b001);

    // Asynchronous reset mid-run with EN held high
    model(3'b010);
    mode = 3'b010; en = 1'b1;
    repeat (100) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset",
          {ADDR, CE, CSB, WEB, OEB, IDATA, BUSY, DONE, PASS, FAIL_ADDR, FAIL_CNT},
          {16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 3'b000, 16'h0, 8'h00});
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    model(3'b010);
    mode = 3'b010;
    wait_done();
    en = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      rm = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(1, 2));
      if ($urandom_range(0, 1) == 1) begin
        flt_addr = $urandom_range(0, N - 1);
        flt_mask = 8'(1 << $urandom_range(0, 7));
        flt_one  = 1'($urandom);
      end else begin
        flt_addr = -1;
      end
      run(rm);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
